// File: rtl/button_pkg.sv
// Shared constants and types for the push-button front end.
// DE1 values assume a 50 MHz system clock.
package button_pkg;

  localparam int DE1_DEBOUNCE_CYCLES = 500_000;    // 10 ms
  localparam int DE1_REPEAT_DELAY    = 25_000_000; // 500 ms
  localparam int DE1_REPEAT_PERIOD   = 5_000_000;  // 100 ms

  typedef enum logic {REL = 1'b0, PRS = 1'b1} btn_level_t;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-FF synchroniser, counter debounce, press/release strobes
// and optional typematic auto-repeat on the press strobe.
module button_channel
  import button_pkg::*;
#(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic level,
  output logic press,
  output logic rel
);

  localparam int   CW       = cnt_w(DEBOUNCE_CYCLES - 1);
  localparam logic IDLE_PIN = (ACTIVE_LOW != 0);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_chk
    $error("button_channel: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  logic          sync1, sync2, s, accept, repeat_fire;
  btn_level_t    lvl;
  logic [CW-1:0] cnt;

  // Synchroniser resets to the idle pin level so reset itself never looks like a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= IDLE_PIN;
      sync2 <= IDLE_PIN;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
    end
  end

  assign s      = sync2 ^ IDLE_PIN;
  assign accept = (btn_level_t'(s) != lvl) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign level  = (lvl == PRS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lvl   <= REL;
      cnt   <= '0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      press <= (accept && s) || repeat_fire;
      rel   <= accept && !s;
      if (accept) begin
        lvl <= btn_level_t'(s);
        cnt <= '0;
      end else if (btn_level_t'(s) == lvl) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  if (REPEAT_EN != 0) begin : g_repeat
    localparam int HW = cnt_w(REPEAT_DELAY);
    // A period longer than the delay cannot be reached by reloading, so it falls back to the delay.
    localparam int RELOAD = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY - REPEAT_PERIOD : 0;

    logic [HW-1:0] hold;
    logic          fire;

    // Never fires on the edge where the level falls: that edge is a release only.
    assign fire = (lvl == PRS) && !accept && (hold == HW'(REPEAT_DELAY - 1));

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        hold <= '0;
      end else if (lvl == REL || accept) begin
        hold <= '0;
      end else if (fire) begin
        hold <= HW'(RELOAD);
      end else if (hold != HW'(REPEAT_DELAY)) begin
        hold <= hold + HW'(1);
      end
    end

    assign repeat_fire = fire;
  end else begin : g_no_repeat
    assign repeat_fire = 1'b0;
  end

endmodule

// File: rtl/button_bank.sv
// N independent debounced push-button channels fanned out from board KEY pins.
// release is a reserved word, so the release strobe port is named rel.
module button_bank
  import button_pkg::*;
#(
  parameter int N               = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] key,
  output logic [N-1:0] level,
  output logic [N-1:0] press,
  output logic [N-1:0] rel
);

  if (N < 1) begin : g_param_chk
    $error("button_bank: N must be >= 1");
  end

  for (genvar i = 0; i < N; i++) begin : g_chan
    button_channel #(
      .ACTIVE_LOW     (ACTIVE_LOW),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_EN      (REPEAT_EN),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_chan (
      .clk  (clk),
      .reset(reset),
      .key  (key[i]),
      .level(level[i]),
      .press(press[i]),
      .rel  (rel[i])
    );
  end

endmodule

// File: tb/tb_button_bank.sv
// Scoreboard bench for button_bank: one instance without and one with auto-repeat,
// both driven by the same keys and checked against a timeline model.
module tb_button_bank;

  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] key   = 4'b0000;
  logic [3:0] lvl0, pr0, rl0, lvl1, pr1, rl1;
  int         checks = 0;
  int         errors = 0;
  bit         done   = 0;

  always #5 clk = ~clk;

  button_bank #(.N(4), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(D), .REPEAT_EN(0),
                .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut0 (
    .clk(clk), .reset(reset), .key(key), .level(lvl0), .press(pr0), .rel(rl0));

  button_bank #(.N(4), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(D), .REPEAT_EN(1),
                .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut1 (
    .clk(clk), .reset(reset), .key(key), .level(lvl1), .press(pr1), .rel(rl1));

  typedef struct packed {
    logic [3:0] lvl0, pr0, rl0, lvl1, pr1, rl1;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] kpipe[$];
  bit         hist[4][$];
  bit         m_lvl[4];
  int         m_age[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: a level is accepted once the last D synchronised samples all
  // disagree with it; repeats fall at DELAY + k*PERIOD edges after the press.
  always @(posedge clk) begin : model
    exp_t       e;
    logic [3:0] samp;
    bit         p, all_dis;
    e = '0;
    if (reset) begin
      kpipe.delete();
      kpipe.push_back(4'hF);
      kpipe.push_back(4'hF);
      for (int c = 0; c < 4; c++) begin
        hist[c].delete();
        m_lvl[c] = 0;
        m_age[c] = 0;
      end
    end else begin
      samp = kpipe.pop_front();
      kpipe.push_back(key);
      for (int c = 0; c < 4; c++) begin
        p = ~samp[c];
        hist[c].push_back(p);
        if (hist[c].size() > D) void'(hist[c].pop_front());
        all_dis = (hist[c].size() == D);
        for (int i = 0; i < hist[c].size(); i++)
          if (hist[c][i] == m_lvl[c]) all_dis = 0;
        if (all_dis) begin
          m_lvl[c] = p;
          if (p) begin
            e.pr0[c] = 1'b1;
            e.pr1[c] = 1'b1;
            m_age[c] = 0;
          end else begin
            e.rl0[c] = 1'b1;
            e.rl1[c] = 1'b1;
          end
        end else if (m_lvl[c]) begin
          m_age[c]++;
          if (m_age[c] >= RD && (m_age[c] - RD) % RP == 0) e.pr1[c] = 1'b1;
        end
        e.lvl0[c] = m_lvl[c];
        e.lvl1[c] = m_lvl[c];
      end
    end
    exp_q.push_back(e);
  end

  // Monitor: one expected entry per clock edge, compared mid-cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: no expected entry at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        if (reset) e = '0;
        check("dut0.level",   {28'd0, lvl0}, {28'd0, e.lvl0});
        check("dut0.press",   {28'd0, pr0},  {28'd0, e.pr0});
        check("dut0.release", {28'd0, rl0},  {28'd0, e.rl0});
        check("dut1.level",   {28'd0, lvl1}, {28'd0, e.lvl1});
        check("dut1.press",   {28'd0, pr1},  {28'd0, e.pr1});
        check("dut1.release", {28'd0, rl1},  {28'd0, e.rl1});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Edges from the first sampling edge until the selected strobe of dut0 rises.
  task automatic measure(input bit use_rel, input int ch, output int lat, output logic [3:0] vec);
    lat = -1;
    vec = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (lat < 0 && (use_rel ? rl0[ch] : pr0[ch])) begin
        lat = i - 1;
        vec = use_rel ? rl0 : pr0;
      end
    end
    cyc(1);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int          lat;
    logic [3:0]  vec;
    logic [31:0] mask;
    bit          found;

    // Reset with all keys down, then release reset with keys up.
    reset = 1'b1;
    key   = 4'b0000;
    cyc(3);
    check("reset.outputs", {8'd0, lvl0, pr0, rl0, lvl1, pr1, rl1}, 32'd0);
    key   = 4'hF;
    reset = 1'b0;
    cyc(20);

    // Single press/release latency on channel 0.
    key = 4'b1110;
    measure(0, 0, lat, vec);
    check("press0.latency", lat, 5);
    check("press0.level", {31'd0, lvl0[0]}, 32'd1);
    key = 4'hF;
    measure(1, 0, lat, vec);
    check("release0.latency", lat, 5);
    check("release0.level", {31'd0, lvl0[0]}, 32'd0);
    cyc(3);

    // Glitch rejection on channel 1, then minimal accepted press.
    key = 4'b1101;
    cyc(3);
    key = 4'hF;
    cyc(10);
    check("glitch1.level", {31'd0, lvl0[1]}, 32'd0);
    key = 4'b1101;
    cyc(4);
    key = 4'hF;
    cyc(12);

    // Auto-repeat timing on channel 2.
    key   = 4'b1011;
    found = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (pr1[2]) begin
        found = 1;
        break;
      end
    end
    check("repeat2.first_press", {31'd0, found}, 32'd1);
    mask = 32'd1;
    for (int k = 1; k < 20; k++) begin
      @(negedge clk);
      mask[k] = pr1[2];
    end
    check("repeat2.offsets", mask, 32'h0002_4901);
    cyc(1);
    key = 4'hF;
    cyc(15);

    // Simultaneous presses on channels 0 and 3.
    key = 4'b0110;
    measure(0, 0, lat, vec);
    check("simul.press_vec", {28'd0, vec}, 32'h9);
    key = 4'hF;
    cyc(10);

    // Reset mid-hold on channel 2 and mid-debounce on channel 0.
    key = 4'b1011;
    cyc(14);
    key = 4'b1010;
    cyc(2);
    reset = 1'b1;
    #1;
    check("async_reset.outputs", {8'd0, lvl0, pr0, rl0, lvl1, pr1, rl1}, 32'd0);
    cyc(2);
    reset = 1'b0;
    measure(0, 0, lat, vec);
    check("post_reset.latency", lat, 5);
    check("post_reset.press_vec", {28'd0, vec}, 32'h5);
    key = 4'hF;
    cyc(12);

    // Random bouncing keys with occasional resets.
    for (int n = 0; n < 700; n++) begin
      if ($urandom_range(0, 7) == 0) key = 4'($urandom);
      else if ($urandom_range(0, 9) == 0) key[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 249) == 0) begin
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
      end
      cyc(1);
    end
    key = 4'hF;
    cyc(12);

    done = 1;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
